// File: rtl/axi4_master_ctrl.sv
// rtl/axi4_master_ctrl.sv - AXI4 burst master for local commands; define AXI4_MASTER_TIMEOUT_EN for the watchdog
module axi4_master_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  done_err,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REJ  = 3'd1;
  localparam logic [2:0] S_AW   = 3'd2;
  localparam logic [2:0] S_W    = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_AR   = 3'd5;
  localparam logic [2:0] S_R    = 3'd6;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] ax_addr;
  logic [7:0]            ax_len;
  logic [2:0]            ax_size;
  logic [7:0]            beat_cnt;
  logic                  rd_err;
  logic                  done_q;
  logic                  done_err_q;

  logic [16:0] burst_bytes;
  logic [16:0] end_off;
  logic        size_bad;
  logic        cross_4k;
  logic        last_beat;
  logic        r_resp_err;
  logic        r_proto_err;
  logic        any_hs;

  // Command legality: beat size must fit the bus and the burst must stay inside one 4KB page
  always_comb begin
    burst_bytes = (17'(cmd_len) + 17'd1) << cmd_size;
    end_off     = 17'(cmd_addr[11:0]) + burst_bytes;
    cross_4k    = end_off > 17'd4096;
    size_bad    = (32'd1 << cmd_size) > 32'(DATA_WIDTH / 8);
  end

  assign last_beat   = (beat_cnt == ax_len);
  assign r_resp_err  = (RRESP != 2'b00);
  // RLAST must coincide exactly with the beat the master counts as last
  assign r_proto_err = RLAST ^ last_beat;
  assign any_hs      = (AWVALID && AWREADY) || (WVALID && WREADY) || (BVALID && BREADY) ||
                       (ARVALID && ARREADY) || (RVALID && RREADY);

  logic wd_fire;

`ifdef AXI4_MASTER_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        wd_active;

  assign wd_active = (state == S_AW) || (state == S_W) || (state == S_B) ||
                     (state == S_AR) || (state == S_R);
  assign wd_fire   = wd_active && !any_hs && ((wd_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
  assign timeout   = timeout_q;

  // Watchdog counts stalled cycles in bus states and restarts on any handshake or state entry
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (!wd_active || any_hs || wd_fire) wd_cnt <= 16'd0;
      else                                 wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  // Watchdog compiled out: never fires
  assign wd_fire = (TIMEOUT_CYCLES < 0) && any_hs;
  assign timeout = 1'b0;
`endif

  // Main sequencer: accept, check, run one AXI burst, report completion one cycle later
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      ax_addr    <= '0;
      ax_len     <= 8'd0;
      ax_size    <= 3'd0;
      beat_cnt   <= 8'd0;
      rd_err     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      if (wd_fire) begin
        state      <= S_IDLE;
        done_q     <= 1'b1;
        done_err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid) begin
            beat_cnt <= 8'd0;
            rd_err   <= 1'b0;
            if (size_bad || cross_4k) begin
              state <= S_REJ;
            end else begin
              ax_addr <= cmd_addr;
              ax_len  <= cmd_len;
              ax_size <= cmd_size;
              state   <= cmd_write ? S_AW : S_AR;
            end
          end
          S_REJ: begin
            state      <= S_IDLE;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
          end
          S_AW: if (AWREADY) state <= S_W;
          S_W: if (WVALID && WREADY) begin
            if (last_beat) state <= S_B;
            else           beat_cnt <= beat_cnt + 8'd1;
          end
          S_B: if (BVALID) begin
            state      <= S_IDLE;
            done_q     <= 1'b1;
            done_err_q <= (BRESP != 2'b00);
          end
          S_AR: if (ARREADY) state <= S_R;
          S_R: if (RVALID && RREADY) begin
            if (RLAST || last_beat) begin
              state      <= S_IDLE;
              done_q     <= 1'b1;
              done_err_q <= rd_err || r_resp_err || r_proto_err;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              rd_err   <= rd_err || r_resp_err;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign done      = done_q;
  assign done_err  = done_err_q;

  assign AWADDR  = ax_addr;
  assign AWLEN   = ax_len;
  assign AWSIZE  = ax_size;
  assign AWVALID = (state == S_AW);
  assign ARADDR  = ax_addr;
  assign ARLEN   = ax_len;
  assign ARSIZE  = ax_size;
  assign ARVALID = (state == S_AR);

  // Write and read data paths are straight wires gated by the active state
  assign WVALID   = (state == S_W) && wr_valid;
  assign wr_ready = (state == S_W) && WREADY;
  assign WDATA    = (state == S_W) ? wr_data : '0;
  assign WLAST    = (state == S_W) && last_beat;
  assign BREADY   = (state == S_B);

  assign RREADY   = (state == S_R) && rd_ready;
  assign rd_valid = (state == S_R) && RVALID;
  assign rd_data  = (state == S_R) ? RDATA : '0;
  assign rd_last  = (state == S_R) && last_beat;

endmodule

// File: tb/tb_axi4_master_ctrl.sv
// tb/tb_axi4_master_ctrl.sv - scoreboard bench for axi4_master_ctrl with a behavioural AXI4 slave
module tb_axi4_master_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done, done_err, timeout;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  logic aw_ready_en, rlast_early, end_req;

  assign AWREADY = aw_ready_en;
  assign WREADY  = 1'b1;
  assign ARREADY = 1'b1;

  always #5 ACLK = ~ACLK;

  axi4_master_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_err(done_err), .timeout(timeout),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Expected-response queues: {addr,len,size}, {data,last}, {err,timeout,latency}
  logic [26:0] exp_aw[$];
  logic [26:0] exp_ar[$];
  logic [32:0] exp_w[$];
  logic [32:0] exp_rd[$];
  logic [9:0]  exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic rst_seen = 1'b0;

  logic [31:0] mem [0:1023];
  logic        s_aw, s_w, s_b, s_ar, s_r;
  logic [15:0] cap_awaddr, cap_araddr, wr_ptr, rd_ptr;
  logic [7:0]  cap_awlen, cap_arlen, rd_cnt, rd_len;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [31:0] cap_wdata;
  logic        cap_wlast, wr_err;
  logic [32:0] e33;
  logic [26:0] e27;
  logic [9:0]  e10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_r();
    RVALID = 1'b1;
    RDATA  = (rd_ptr < 16'h1000) ? mem[rd_ptr[11:2]] : 32'h0;
    RRESP  = (rd_ptr < 16'h1000) ? 2'b00 : 2'b10;
    RLAST  = (rd_cnt == rd_len) || rlast_early;
  endtask

  // Monitor and slave model: compare at negedge, respond just after posedge
  always begin
    @(negedge ACLK);
    cyc++;
    s_aw = 1'b0; s_w = 1'b0; s_b = 1'b0; s_ar = 1'b0; s_r = 1'b0;
    if (ARESET) begin
      chk("reset_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, done, done_err, timeout, wr_ready, rd_valid}, 0);
      chk("reset_fields", {AWADDR, AWLEN, AWSIZE, ARADDR, ARLEN, ARSIZE}, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("cmd_ready_after_reset", cmd_ready, 1);
        rst_seen = 1'b0;
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (AWVALID || ARVALID) chk("aw_ar_exclusive", AWVALID && ARVALID, 0);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_queue_nonempty", exp_rd.size(), 1);
        else begin
          e33 = exp_rd.pop_front();
          chk("rd_beat", {rd_data, rd_last}, e33);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_queue_nonempty", exp_done.size(), 1);
        else begin
          e10 = exp_done.pop_front();
          chk("done_flags", {done_err, timeout}, e10[9:8]);
          if (e10[7:0] != 8'd0) chk("done_latency", cyc - acc_cyc, e10[7:0]);
        end
      end
      s_aw = AWVALID && AWREADY; cap_awaddr = AWADDR; cap_awlen = AWLEN; cap_awsize = AWSIZE;
      s_w  = WVALID && WREADY;   cap_wdata = WDATA;   cap_wlast = WLAST;
      s_b  = BVALID && BREADY;
      s_ar = ARVALID && ARREADY; cap_araddr = ARADDR; cap_arlen = ARLEN; cap_arsize = ARSIZE;
      s_r  = RVALID && RREADY;
      if (end_req) begin
        chk("queues_drained", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
    @(posedge ACLK);
    #1;
    if (ARESET) begin
      BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = 32'h0;
      wr_err = 1'b0;
    end else begin
      if (s_b) BVALID = 1'b0;
      if (s_aw) begin
        if (exp_aw.size() == 0) chk("aw_queue_nonempty", exp_aw.size(), 1);
        else begin
          e27 = exp_aw.pop_front();
          chk("aw_fields", {cap_awaddr, cap_awlen, cap_awsize}, e27);
        end
        wr_ptr = cap_awaddr;
        wr_err = 1'b0;
      end
      if (s_w) begin
        if (exp_w.size() == 0) chk("w_queue_nonempty", exp_w.size(), 1);
        else begin
          e33 = exp_w.pop_front();
          chk("w_beat", {cap_wdata, cap_wlast}, e33);
        end
        if (wr_ptr < 16'h1000) mem[wr_ptr[11:2]] = cap_wdata;
        else                   wr_err = 1'b1;
        wr_ptr = wr_ptr + 16'd4;
        if (cap_wlast) begin
          BVALID = 1'b1;
          BRESP  = wr_err ? 2'b10 : 2'b00;
        end
      end
      if (s_ar) begin
        if (exp_ar.size() == 0) chk("ar_queue_nonempty", exp_ar.size(), 1);
        else begin
          e27 = exp_ar.pop_front();
          chk("ar_fields", {cap_araddr, cap_arlen, cap_arsize}, e27);
        end
        rd_ptr = cap_araddr;
        rd_cnt = 8'd0;
        rd_len = cap_arlen;
        drive_r();
      end else if (s_r) begin
        if (RLAST) RVALID = 1'b0;
        else begin
          rd_ptr = rd_ptr + 16'd4;
          rd_cnt = rd_cnt + 8'd1;
          drive_r();
        end
      end
    end
  end

  task automatic bound_fail(input string name);
    $display("FAIL bound_%s: DUT did not respond within the cycle budget", name);
    $fatal(1, "stalled");
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
    for (int i = 0; ; i++) begin
      if (i > 100) bound_fail("cmd_accept");
      @(negedge ACLK);
      if (cmd_ready) break;
    end
    @(posedge ACLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_wdata(input int nb, input logic [31:0] d0);
    int beat;
    logic hs;
    beat = 0; wr_valid = 1'b1; wr_data = d0;
    for (int i = 0; beat < nb; i++) begin
      if (i > 200) bound_fail("wdata");
      @(negedge ACLK);
      hs = wr_valid && wr_ready;
      @(posedge ACLK);
      #1;
      if (hs) begin
        beat++;
        wr_data = d0 + 32'(beat);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input logic tog);
    for (int i = 0; ; i++) begin
      if (i > 200) bound_fail("done");
      @(negedge ACLK);
      if (done) break;
      @(posedge ACLK);
      #1;
      if (tog) rd_ready = !rd_ready;
    end
    @(posedge ACLK);
    #1 rd_ready = 1'b1;
  endtask

  task automatic push_beats(input logic is_rd, input int n, input logic [31:0] d0, input logic inc, input int last_idx);
    for (int i = 0; i < n; i++) begin
      if (is_rd) exp_rd.push_back({inc ? d0 + 32'(i) : d0, i == last_idx});
      else       exp_w.push_back({inc ? d0 + 32'(i) : d0, i == last_idx});
    end
  endtask

  initial begin
    ARESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0; cmd_size = 3'h0;
    wr_data = 32'h0; wr_valid = 1'b0; rd_ready = 1'b1;
    aw_ready_en = 1'b1; rlast_early = 1'b0; end_req = 1'b0;
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #3 ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Write 4 beats A0..A3 to 0x0010
    exp_aw.push_back({16'h0010, 8'd3, 3'd2});
    push_beats(0, 4, 32'hA0, 1, 3);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(1, 16'h0010, 8'd3, 3'd2);
    send_wdata(4, 32'hA0);
    wait_done(0);

    // Read back with rd_ready toggling
    exp_ar.push_back({16'h0010, 8'd3, 3'd2});
    push_beats(1, 4, 32'hA0, 1, 3);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(0, 16'h0010, 8'd3, 3'd2);
    wait_done(1);

    // 4KB crossing: 0xFF8 + 16 bytes > 4096, rejected two cycles after accept
    exp_done.push_back({1'b1, 1'b0, 8'd2});
    send_cmd(1, 16'h0FF8, 8'd3, 3'd2);
    wait_done(0);

    // 8-byte beats on a 32-bit bus are rejected the same way
    exp_done.push_back({1'b1, 1'b0, 8'd2});
    send_cmd(1, 16'h0020, 8'd0, 3'd3);
    wait_done(0);

    // Read outside slave range: SLVERR on each beat
    exp_ar.push_back({16'h1000, 8'd1, 3'd2});
    push_beats(1, 2, 32'h0, 0, 1);
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    send_cmd(0, 16'h1000, 8'd1, 3'd2);
    wait_done(0);

    // Burst ending exactly at the 4KB boundary is legal
    exp_aw.push_back({16'h0FF0, 8'd3, 3'd2});
    push_beats(0, 4, 32'hB0, 1, 3);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(1, 16'h0FF0, 8'd3, 3'd2);
    send_wdata(4, 32'hB0);
    wait_done(0);
    exp_ar.push_back({16'h0FF0, 8'd3, 3'd2});
    push_beats(1, 4, 32'hB0, 1, 3);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(0, 16'h0FF0, 8'd3, 3'd2);
    wait_done(0);

    // Write response error
    exp_aw.push_back({16'h1000, 8'd0, 3'd2});
    push_beats(0, 1, 32'hD0, 0, 0);
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    send_cmd(1, 16'h1000, 8'd0, 3'd2);
    send_wdata(1, 32'hD0);
    wait_done(0);

    // Early RLAST on beat 0 of a 4-beat read: burst ends, protocol error
    rlast_early = 1'b1;
    exp_ar.push_back({16'h0010, 8'd3, 3'd2});
    push_beats(1, 1, 32'hA0, 0, 5);
    exp_done.push_back({1'b1, 1'b0, 8'd0});
    send_cmd(0, 16'h0010, 8'd3, 3'd2);
    wait_done(0);
    rlast_early = 1'b0;

    // Reset during beat 2 of an 8-beat write, no completion expected
    exp_aw.push_back({16'h0100, 8'd7, 3'd2});
    push_beats(0, 2, 32'hC0, 1, 9);
    send_cmd(1, 16'h0100, 8'd7, 3'd2);
    send_wdata(2, 32'hC0);
    wr_valid = 1'b1; wr_data = 32'hC2;
    #2 ARESET = 1'b1;
    @(posedge ACLK);
    @(posedge ACLK);
    #3 ARESET = 1'b0;
    wr_valid = 1'b0;
    @(posedge ACLK);
    #1;

    // Normal traffic after reset
    exp_aw.push_back({16'h0200, 8'd1, 3'd2});
    push_beats(0, 2, 32'hE0, 1, 1);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(1, 16'h0200, 8'd1, 3'd2);
    send_wdata(2, 32'hE0);
    wait_done(0);
    exp_ar.push_back({16'h0200, 8'd1, 3'd2});
    push_beats(1, 2, 32'hE0, 1, 1);
    exp_done.push_back({1'b0, 1'b0, 8'd0});
    send_cmd(0, 16'h0200, 8'd1, 3'd2);
    wait_done(1);

`ifdef AXI4_MASTER_TIMEOUT_EN
    // AWREADY held low: watchdog aborts after 16 stalled cycles
    aw_ready_en = 1'b0;
    exp_done.push_back({1'b1, 1'b1, 8'd17});
    send_cmd(1, 16'h0300, 8'd0, 3'd2);
    wait_done(0);
    aw_ready_en = 1'b1;
`endif

    end_req = 1'b1;
    #100;
    $display("FAIL bound_summary: monitor did not close the run");
    $fatal(1, "stalled");
  end

  initial begin
    #100000;
    $display("FAIL bound_global: simulation time limit reached");
    $fatal(1, "stalled");
  end

endmodule
